// File: rtl/desc_slot_scheduler.sv
// desc_slot_scheduler
// Hands packet descriptors from the ingress stream to one of CORE_COUNT core
// wrappers. Each core has a slot credit count. A core is eligible when it is
// enabled and has at least one free slot. Among eligible cores the choice is
// round-robin.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   s_desc*         ingress descriptor stream (valid/ready)
//   m_desc          shared descriptor bus to the cores
//   m_desc_valid    one-hot offer to the selected core
//   m_desc_taken    per-core accept of the current offer
//   slot_release    per-core pulse, one per freed packet slot
//   core_enable     per-core eligibility for new work
//   core_flush      per-core credit restore to SLOT_COUNT; withdraws its offer
//   free_slots      packed credits, core i at [i*SLOT_W +: SLOT_W]
//   credit_err      sticky per-core flag: release seen while already at full credit
//   stat_sel        core select for stat_data
//   stat_data       dispatch count of the selected core
//
// Optional build macro DESC_SCHED_STATS_EN enables the per-core 32-bit
// dispatch counters. When the macro is not defined, stat_data reads 0.
module desc_slot_scheduler #(
    parameter int CORE_COUNT = 8,
    parameter int SLOT_COUNT = 16,
    parameter int DESC_WIDTH = 64,
    parameter int SLOT_W     = $clog2(SLOT_COUNT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DESC_WIDTH-1:0]        s_desc,
    input  logic                         s_desc_valid,
    output logic                         s_desc_ready,
    output logic [DESC_WIDTH-1:0]        m_desc,
    output logic [CORE_COUNT-1:0]        m_desc_valid,
    input  logic [CORE_COUNT-1:0]        m_desc_taken,
    input  logic [CORE_COUNT-1:0]        slot_release,
    input  logic [CORE_COUNT-1:0]        core_enable,
    input  logic [CORE_COUNT-1:0]        core_flush,
    output logic [CORE_COUNT*SLOT_W-1:0] free_slots,
    output logic [CORE_COUNT-1:0]        credit_err,
    input  logic [$clog2(CORE_COUNT)-1:0] stat_sel,
    output logic [31:0]                  stat_data
);

    localparam int IDX_W = $clog2(CORE_COUNT);
    localparam logic [SLOT_W-1:0] FULL = SLOT_W'(SLOT_COUNT);

    logic [DESC_WIDTH-1:0] hold_desc;
    logic                  hold_valid;
    logic [IDX_W-1:0]      lock_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [SLOT_W-1:0]     credit [CORE_COUNT];

    logic [CORE_COUNT-1:0] eligible;
    logic [CORE_COUNT-1:0] take_vec;
    logic [CORE_COUNT-1:0] sel_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  offering;
    logic                  take;
    logic                  accept;
    logic                  flush_lock;
    int                    cand;

    // An offer is in progress whenever a valid bit is registered. m_desc_taken
    // is masked by that bit, so an accept from a core that was not offered
    // anything has no effect.
    assign offering     = |m_desc_valid;
    assign take_vec     = m_desc_valid & m_desc_taken;
    assign take         = |take_vec;
    assign s_desc_ready = !hold_valid || take;
    assign accept       = s_desc_valid && s_desc_ready;
    assign flush_lock   = offering && core_flush[lock_idx];

    // Round-robin search: take the first eligible core strictly after rr_ptr,
    // wrapping around. A zero credit removes a core from the search, so a core
    // with no free slot is never offered work.
    always_comb begin
        eligible   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        cand       = 0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            eligible[i] = core_enable[i] && (credit[i] != '0);
        end
        for (int k = 1; k <= CORE_COUNT; k++) begin
            cand = (int'(rr_ptr) + k) % CORE_COUNT;
            if (!sel_found && eligible[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        if (sel_found) begin
            sel_onehot = CORE_COUNT'(1) << sel_idx;
        end
    end

    // Holding register and offer lock. A take has the highest priority. When a
    // take coincides with a new accept, the new descriptor waits one cycle in
    // SELECT so the next choice sees the updated credits. A descriptor accepted
    // while idle can go straight to an offer. A flush of the locked core only
    // withdraws the offer; the descriptor stays held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_desc    <= '0;
            hold_valid   <= 1'b0;
            lock_idx     <= '0;
            rr_ptr       <= IDX_W'(CORE_COUNT - 1);
            m_desc_valid <= '0;
            m_desc       <= '0;
        end else if (take) begin
            rr_ptr       <= lock_idx;
            m_desc_valid <= '0;
            hold_valid   <= accept;
            if (accept) begin
                hold_desc <= s_desc;
            end
        end else if (flush_lock) begin
            m_desc_valid <= '0;
        end else if (!hold_valid) begin
            if (accept) begin
                hold_desc  <= s_desc;
                hold_valid <= 1'b1;
                if (sel_found) begin
                    lock_idx     <= sel_idx;
                    m_desc_valid <= sel_onehot;
                    m_desc       <= s_desc;
                end
            end
        end else if (!offering && sel_found) begin
            lock_idx     <= sel_idx;
            m_desc_valid <= sel_onehot;
            m_desc       <= hold_desc;
        end
    end

    // Per-core credits. A flush wins over everything else. A take and a release
    // in the same cycle cancel out. A release at full credit saturates and sets
    // the sticky error flag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (rst) begin
                credit[i]     <= FULL;
                credit_err[i] <= 1'b0;
            end else if (core_flush[i]) begin
                credit[i] <= FULL;
            end else if (take_vec[i] && slot_release[i]) begin
                credit[i] <= credit[i];
            end else if (take_vec[i]) begin
                credit[i] <= credit[i] - 1'b1;
            end else if (slot_release[i]) begin
                if (credit[i] == FULL) begin
                    credit_err[i] <= 1'b1;
                end else begin
                    credit[i] <= credit[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_slots = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            free_slots[i*SLOT_W +: SLOT_W] = credit[i];
        end
    end

`ifdef DESC_SCHED_STATS_EN
    logic [31:0] disp_cnt [CORE_COUNT];

    // Wrapping per-core dispatch counters. A core's flush clears its counter.
    // The selected counter is read through a register, so stat_data shows the
    // value one cycle after stat_sel is applied.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (rst || core_flush[i]) begin
                disp_cnt[i] <= '0;
            end else if (take_vec[i]) begin
                disp_cnt[i] <= disp_cnt[i] + 32'd1;
            end
        end
        if (rst) begin
            stat_data <= '0;
        end else begin
            stat_data <= disp_cnt[stat_sel];
        end
    end
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_data       = '0;
`endif

endmodule

// File: tb/tb_desc_slot_scheduler.sv
// Directed self-checking bench for desc_slot_scheduler with its default
// parameters (8 cores, 16 slots, 64-bit descriptors, 5-bit credits).
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_desc_slot_scheduler;

    localparam int NC = 8;
    localparam int SW = 5;

    logic           clk;
    logic           rst;
    logic [63:0]    s_desc;
    logic           s_desc_valid;
    logic           s_desc_ready;
    logic [63:0]    m_desc;
    logic [NC-1:0]  m_desc_valid;
    logic [NC-1:0]  m_desc_taken;
    logic [NC-1:0]  slot_release;
    logic [NC-1:0]  core_enable;
    logic [NC-1:0]  core_flush;
    logic [NC*SW-1:0] free_slots;
    logic [NC-1:0]  credit_err;
    logic [2:0]     stat_sel;
    logic [31:0]    stat_data;

    int checks;
    int failures;

    desc_slot_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .s_desc       (s_desc),
        .s_desc_valid (s_desc_valid),
        .s_desc_ready (s_desc_ready),
        .m_desc       (m_desc),
        .m_desc_valid (m_desc_valid),
        .m_desc_taken (m_desc_taken),
        .slot_release (slot_release),
        .core_enable  (core_enable),
        .core_flush   (core_flush),
        .free_slots   (free_slots),
        .credit_err   (credit_err),
        .stat_sel     (stat_sel),
        .stat_data    (stat_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [SW-1:0] creditOf(input int i);
        return free_slots[i*SW +: SW];
    endfunction

    // Present one descriptor from idle. Check that it is offered to the
    // expected core on the next cycle, then take it.
    task automatic applyStimulus(input logic [63:0] d, input int core, input string tag);
        logic [NC-1:0] onehot;
        onehot = NC'(1) << core;
        s_desc       = d;
        s_desc_valid = 1'b1;
        checkOutput({tag, "_ready"}, 64'(s_desc_ready), 64'd1);
        step();
        s_desc_valid = 1'b0;
        checkOutput({tag, "_valid"}, 64'(m_desc_valid), 64'(onehot));
        checkOutput({tag, "_desc"}, m_desc, d);
        m_desc_taken = onehot;
        step();
        m_desc_taken = '0;
        checkOutput({tag, "_clear"}, 64'(m_desc_valid), 64'd0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        s_desc       = '0;
        s_desc_valid = 1'b0;
        m_desc_taken = '0;
        slot_release = '0;
        core_enable  = '0;
        core_flush   = '0;
        stat_sel     = '0;
        @(negedge clk);
        step();
        step();

        // Reset values
        checkOutput("rst_valid", 64'(m_desc_valid), 64'd0);
        checkOutput("rst_desc", m_desc, 64'd0);
        checkOutput("rst_ready", 64'(s_desc_ready), 64'd1);
        checkOutput("rst_err", 64'(credit_err), 64'd0);
        checkOutput("rst_slots", 64'(free_slots), 64'({8{5'd16}}));
        checkOutput("rst_stat", 64'(stat_data), 64'd0);
        rst = 1'b0;

        // Round-robin across all cores
        core_enable = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(64'hA000_0000_0000_0000 + 64'(k), k, $sformatf("rr%0d", k));
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_credit%0d", k), 64'(creditOf(k)), 64'd15);
        end

        // Credit exhaustion on core 2
        pulseReset();
        core_enable = 8'h04;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(64'hB000 + 64'(k), 2, $sformatf("ex%0d", k));
        end
        checkOutput("ex_credit0", 64'(creditOf(2)), 64'd0);
        d = 64'hB0B0_1717;
        s_desc       = d;
        s_desc_valid = 1'b1;
        step();
        s_desc_valid = 1'b0;
        checkOutput("ex17_valid", 64'(m_desc_valid), 64'd0);
        checkOutput("ex17_ready", 64'(s_desc_ready), 64'd0);
        step();
        step();
        checkOutput("ex17_still", 64'(m_desc_valid), 64'd0);
        slot_release = 8'h04;
        step();
        slot_release = '0;
        checkOutput("ex17_wait", 64'(m_desc_valid), 64'd0);
        step();
        checkOutput("ex17_offer", 64'(m_desc_valid), 64'h04);
        checkOutput("ex17_desc", m_desc, d);
        m_desc_taken = 8'h04;
        step();
        m_desc_taken = '0;
        checkOutput("ex17_credit", 64'(creditOf(2)), 64'd0);
        checkOutput("ex17_ready2", 64'(s_desc_ready), 64'd1);

        // Simultaneous take and release, then a release at full credit
        pulseReset();
        core_enable = 8'h02;
        for (int k = 0; k < 11; k++) begin
            applyStimulus(64'hC000 + 64'(k), 1, $sformatf("sim%0d", k));
        end
        checkOutput("sim_credit5", 64'(creditOf(1)), 64'd5);
        d = 64'hC0C0_0005;
        s_desc       = d;
        s_desc_valid = 1'b1;
        step();
        s_desc_valid = 1'b0;
        checkOutput("sim_offer", 64'(m_desc_valid), 64'h02);
        m_desc_taken = 8'h02;
        slot_release = 8'h02;
        step();
        m_desc_taken = '0;
        slot_release = '0;
        checkOutput("sim_both", 64'(creditOf(1)), 64'd5);
        core_flush = 8'h02;
        step();
        core_flush = '0;
        checkOutput("sim_flush", 64'(creditOf(1)), 64'd16);
        checkOutput("sim_noerr", 64'(credit_err), 64'd0);
        slot_release = 8'h02;
        step();
        slot_release = '0;
        checkOutput("sim_sat", 64'(creditOf(1)), 64'd16);
        checkOutput("sim_err", 64'(credit_err), 64'h02);

        // Flush of the locked core withdraws the offer and re-offers elsewhere
        pulseReset();
        core_enable = 8'h18;
        d = 64'hD00D_F1F1;
        s_desc       = d;
        s_desc_valid = 1'b1;
        step();
        s_desc_valid = 1'b0;
        checkOutput("fl_offer3", 64'(m_desc_valid), 64'h08);
        core_enable = 8'h10;
        core_flush  = 8'h08;
        step();
        core_flush = '0;
        checkOutput("fl_withdraw", 64'(m_desc_valid), 64'd0);
        checkOutput("fl_credit3", 64'(creditOf(3)), 64'd16);
        step();
        checkOutput("fl_offer4", 64'(m_desc_valid), 64'h10);
        checkOutput("fl_desc", m_desc, d);
        m_desc_taken = 8'h10;
        step();
        m_desc_taken = '0;
        checkOutput("fl_credit4", 64'(creditOf(4)), 64'd15);

        // Backpressure: the offer holds while the core stalls, survives a
        // dropped enable, and ignores a take from another core
        pulseReset();
        core_enable = 8'h01;
        d = 64'hE1E1_2222_3333_4444;
        s_desc       = d;
        s_desc_valid = 1'b1;
        step();
        s_desc_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) core_enable = '0;
            if (c >= 6) m_desc_taken = 8'h02;
            step();
            checkOutput($sformatf("bp_valid%0d", c), 64'(m_desc_valid), 64'h01);
            checkOutput($sformatf("bp_desc%0d", c), m_desc, d);
        end
        m_desc_taken = '0;
        checkOutput("bp_ready", 64'(s_desc_ready), 64'd0);
        checkOutput("bp_credit1", 64'(creditOf(1)), 64'd16);
        pulseReset();
        repeat (5) step();
        checkOutput("bp_rst_valid", 64'(m_desc_valid), 64'd0);
        checkOutput("bp_rst_desc", m_desc, 64'd0);
        checkOutput("bp_rst_ready", 64'(s_desc_ready), 64'd1);
        checkOutput("bp_rst_slots", 64'(free_slots), 64'({8{5'd16}}));
        checkOutput("bp_rst_err", 64'(credit_err), 64'd0);

        // Dispatch statistics for core 5
        pulseReset();
        core_enable = 8'h20;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(64'hF000 + 64'(k), 5, $sformatf("st%0d", k));
        end
        stat_sel = 3'd5;
        step();
`ifdef DESC_SCHED_STATS_EN
        checkOutput("stat_core5", 64'(stat_data), 64'd3);
`else
        checkOutput("stat_core5", 64'(stat_data), 64'd0);
`endif
        stat_sel = 3'd4;
        step();
        checkOutput("stat_core4", 64'(stat_data), 64'd0);
        stat_sel    = 3'd5;
        core_flush  = 8'h20;
        step();
        core_flush = '0;
        step();
        checkOutput("stat_flushed", 64'(stat_data), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
